// File: rtl/sdram_arb_pkg.sv
// ---------------------------------------------------------------------------
// sdram_arb_pkg
// Shared types and defaults for the SDRAM arbiter slice.
//   state_t : arbiter FSM states (IDLE, ISSUE, DONE)
//   owner_t : which requester owns the controller for the current command
//   ARB_ADDR_W / ARB_DATA_W : default word-address and data widths
// ---------------------------------------------------------------------------
package sdram_arb_pkg;

    localparam int ARB_ADDR_W = 22;
    localparam int ARB_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_VID  = 2'd1,
        OWN_REF  = 2'd2,
        OWN_CPU  = 2'd3
    } owner_t;

    // A completed command returns data only for video reads and CPU reads.
    function automatic logic owner_gets_data(owner_t owner, logic is_write);
        return (owner == OWN_VID) || ((owner == OWN_CPU) && !is_write);
    endfunction

endpackage

// File: rtl/sdram_arbiter_if.sv
// ---------------------------------------------------------------------------
// sdram_arbiter_if
// Command/response bus between the arbiter and the SDRAM controller.
//   mem_addr/mem_dataw    : word address and write data (controller iaddr/dataw)
//   mem_rd/mem_we_n       : read strobe / active-low write strobe
//   mem_lb_n/mem_ub_n     : active-low byte masks (controller ilb_n/iub_n)
//   mem_refresh           : refresh strobe
//   mem_datar/mem_busy    : read data and busy flag from the controller
// Modports: master = arbiter side, slave = controller side.
// ---------------------------------------------------------------------------
interface sdram_arbiter_if
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
) ();

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_dataw;
    logic              mem_rd;
    logic              mem_we_n;
    logic              mem_lb_n;
    logic              mem_ub_n;
    logic              mem_refresh;
    logic [DATA_W-1:0] mem_datar;
    logic              mem_busy;

    modport master (
        output mem_addr, mem_dataw, mem_rd, mem_we_n, mem_lb_n, mem_ub_n, mem_refresh,
        input  mem_datar, mem_busy
    );

    modport slave (
        input  mem_addr, mem_dataw, mem_rd, mem_we_n, mem_lb_n, mem_ub_n, mem_refresh,
        output mem_datar, mem_busy
    );

endinterface

// File: rtl/refresh_timer.sv
// ---------------------------------------------------------------------------
// refresh_timer
// Free-running refresh tick generator with a saturating owed-refresh count.
//   clk, reset_n   : clock, asynchronous active-low reset
//   grant_ref      : the arbiter is granting a refresh this cycle
//   refresh_owed   : number of refreshes due but not yet granted (0..3)
//   refresh_miss   : sticky, a tick arrived while the count was already 3
// ---------------------------------------------------------------------------
module refresh_timer #(
    parameter int REFRESH_PERIOD = 780
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       grant_ref,
    output logic [1:0] refresh_owed,
    output logic       refresh_miss
);

    localparam int                CNT_W  = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
    localparam logic [CNT_W-1:0]  RELOAD = CNT_W'(REFRESH_PERIOD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       owed_q, owed_d;
    logic             miss_q, miss_d;
    logic             tick;

    always_comb begin
        tick   = (cnt_q == '0);
        cnt_d  = tick ? RELOAD : (cnt_q - 1'b1);
        owed_d = owed_q;
        miss_d = miss_q;
        // A tick coinciding with a grant cancels out, so it is never counted as dropped.
        if (tick && !grant_ref) begin
            if (owed_q == 2'd3) begin
                miss_d = 1'b1;
            end else begin
                owed_d = owed_q + 2'd1;
            end
        end else if (!tick && grant_ref && (owed_q != 2'd0)) begin
            owed_d = owed_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= RELOAD;
            owed_q <= 2'd0;
            miss_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            owed_q <= owed_d;
            miss_q <= miss_d;
        end
    end

    assign refresh_owed = owed_q;
    assign refresh_miss = miss_q;

endmodule

// File: rtl/sdram_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_arbiter
// Fixed-priority scheduler sharing one SDRAM controller between the video
// fetcher, the CPU and the refresh timer. One command in flight at a time.
//   clk, reset_n                    : clock, asynchronous active-low reset
//   vid_req/vid_addr                : video read request (held until vid_ack)
//   vid_ack/vid_data/vid_valid      : grant pulse, read data, data-valid pulse
//   cpu_req/cpu_we/cpu_addr/
//   cpu_wdata/cpu_lb_n/cpu_ub_n     : CPU request (held until cpu_ack)
//   cpu_ack/cpu_rdata/cpu_valid     : grant pulse, read data, data-valid pulse
//   mem                             : controller command bus (master side)
//   refresh_owed/refresh_miss       : refresh bookkeeping from refresh_timer
// Priority in IDLE: refresh (owed>=2) > video > refresh (owed==1) > CPU.
// ---------------------------------------------------------------------------
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int REFRESH_PERIOD = 780,
    parameter int ADDR_W         = ARB_ADDR_W,
    parameter int DATA_W         = ARB_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_valid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_lb_n,
    input  logic              cpu_ub_n,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_valid,
    sdram_arbiter_if.master   mem,
    output logic [1:0]        refresh_owed,
    output logic              refresh_miss
);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dataw_q, dataw_d;
    logic              lb_n_q, lb_n_d;
    logic              ub_n_q, ub_n_d;
    logic              rd_q, rd_d;
    logic              we_n_q, we_n_d;
    logic              ref_q, ref_d;
    logic              vid_ack_q, vid_ack_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              vid_valid_q, vid_valid_d;
    logic              cpu_valid_q, cpu_valid_d;
    logic [DATA_W-1:0] vid_data_q, vid_data_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              grant_ref;

    refresh_timer #(
        .REFRESH_PERIOD(REFRESH_PERIOD)
    ) u_refresh_timer (
        .clk          (clk),
        .reset_n      (reset_n),
        .grant_ref    (grant_ref),
        .refresh_owed (refresh_owed),
        .refresh_miss (refresh_miss)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        dataw_d     = dataw_q;
        lb_n_d      = lb_n_q;
        ub_n_d      = ub_n_q;
        rd_d        = rd_q;
        we_n_d      = we_n_q;
        ref_d       = ref_q;
        vid_ack_d   = 1'b0;
        cpu_ack_d   = 1'b0;
        vid_valid_d = 1'b0;
        cpu_valid_d = 1'b0;
        vid_data_d  = vid_data_q;
        cpu_rdata_d = cpu_rdata_q;
        grant_ref   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // A single owed refresh yields to video but not to the CPU.
                if ((refresh_owed >= 2'd2) || (!vid_req && (refresh_owed == 2'd1))) begin
                    grant_ref = 1'b1;
                    owner_d   = OWN_REF;
                    wr_d      = 1'b0;
                    ref_d     = 1'b1;
                    state_d   = ISSUE;
                end else if (vid_req) begin
                    owner_d   = OWN_VID;
                    wr_d      = 1'b0;
                    addr_d    = vid_addr;
                    lb_n_d    = 1'b0;
                    ub_n_d    = 1'b0;
                    rd_d      = 1'b1;
                    vid_ack_d = 1'b1;
                    state_d   = ISSUE;
                end else if (cpu_req) begin
                    owner_d   = OWN_CPU;
                    wr_d      = cpu_we;
                    addr_d    = cpu_addr;
                    dataw_d   = cpu_wdata;
                    lb_n_d    = cpu_lb_n;
                    ub_n_d    = cpu_ub_n;
                    rd_d      = !cpu_we;
                    we_n_d    = !cpu_we;
                    cpu_ack_d = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                // Controller has accepted the command once it reports busy.
                if (mem.mem_busy) begin
                    rd_d    = 1'b0;
                    we_n_d  = 1'b1;
                    ref_d   = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!mem.mem_busy) begin
                    if (owner_gets_data(owner_q, wr_q)) begin
                        if (owner_q == OWN_VID) begin
                            vid_data_d  = mem.mem_datar;
                            vid_valid_d = 1'b1;
                        end else begin
                            cpu_rdata_d = mem.mem_datar;
                            cpu_valid_d = 1'b1;
                        end
                    end
                    owner_d = OWN_NONE;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            owner_q     <= OWN_NONE;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            dataw_q     <= '0;
            lb_n_q      <= 1'b1;
            ub_n_q      <= 1'b1;
            rd_q        <= 1'b0;
            we_n_q      <= 1'b1;
            ref_q       <= 1'b0;
            vid_ack_q   <= 1'b0;
            cpu_ack_q   <= 1'b0;
            vid_valid_q <= 1'b0;
            cpu_valid_q <= 1'b0;
            vid_data_q  <= '0;
            cpu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            dataw_q     <= dataw_d;
            lb_n_q      <= lb_n_d;
            ub_n_q      <= ub_n_d;
            rd_q        <= rd_d;
            we_n_q      <= we_n_d;
            ref_q       <= ref_d;
            vid_ack_q   <= vid_ack_d;
            cpu_ack_q   <= cpu_ack_d;
            vid_valid_q <= vid_valid_d;
            cpu_valid_q <= cpu_valid_d;
            vid_data_q  <= vid_data_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    assign mem.mem_addr    = addr_q;
    assign mem.mem_dataw   = dataw_q;
    assign mem.mem_rd      = rd_q;
    assign mem.mem_we_n    = we_n_q;
    assign mem.mem_lb_n    = lb_n_q;
    assign mem.mem_ub_n    = ub_n_q;
    assign mem.mem_refresh = ref_q;

    assign vid_ack   = vid_ack_q;
    assign cpu_ack   = cpu_ack_q;
    assign vid_valid = vid_valid_q;
    assign cpu_valid = cpu_valid_q;
    assign vid_data  = vid_data_q;
    assign cpu_rdata = cpu_rdata_q;

endmodule
